// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : RV32I ALU decode-and-issue stage with a 2-entry skid buffer
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [2:0]       out_alu_control,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int ENTRY_W = 2*XLEN + 3 + 5 + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_tail;
    logic [ENTRY_W-1:0] w_new;
    logic [CNT_W-1:0]   r_cnt;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_b;
    logic [2:0]      w_ctrl;
    logic            w_ill;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_rs1_field;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    // Register indices are resolved upstream; only the operand values matter here.
    assign w_unused_rs1_field = ^in_instr[19:15];

    always_comb begin
        w_ctrl = 3'b111;
        w_b    = in_rs2_val;
        w_ill  = 1'b1;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  begin w_ctrl = 3'b000; w_ill = 1'b0; end
                        3'b111:  begin w_ctrl = 3'b010; w_ill = 1'b0; end
                        3'b110:  begin w_ctrl = 3'b011; w_ill = 1'b0; end
                        default: ;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_ctrl = 3'b001;
                    w_ill  = 1'b0;
                end
            end
            7'b0010011: begin
                case (w_funct3)
                    3'b000:  begin w_ctrl = 3'b000; w_b = w_imm; w_ill = 1'b0; end
                    3'b111:  begin w_ctrl = 3'b010; w_b = w_imm; w_ill = 1'b0; end
                    3'b110:  begin w_ctrl = 3'b011; w_b = w_imm; w_ill = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign w_new     = {in_rs1_val, w_b, w_ctrl, in_instr[11:7], w_ill};
    assign in_ready  = (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign {out_a, out_b, out_alu_control, out_rd, out_illegal} = r_head;
    assign illegal_count = r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_next = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_next = S_TWO;
                else if (!w_push && w_pop) w_next = S_EMPTY;
            end
            S_TWO:   if (w_pop) w_next = S_ONE;
            default: w_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_EMPTY: if (w_push) r_head <= w_new;
                S_ONE: begin
                    // Simultaneous push/pop replaces the head so the tail stays unused.
                    if (w_push && w_pop) r_head <= w_new;
                    else if (w_push)     r_tail <= w_new;
                end
                S_TWO:   if (w_pop) r_head <= r_tail;
                default: ;
            endcase
            if (w_push && w_ill && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
